prog_clock_divider: RTL

//  Synchronous, parametrised divide-by-M counter. Replaces cascaded toggle-stage

---
 rtl/prog_clock_divider.sv | 80 ++++++++
 1 files changed

// File: rtl/prog_clock_divider.sv
// Purpose : programmable divide-by-M enable generator (pulse tick or 50% square output).
// Latency : Tick/Y rise one cycle after the edge that samples cnt == m_act-1.
// Backpressure: none; En low freezes the phase, Restart reloads it (Restart wins).
module prog_clock_divider #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             En,
    input  logic             Restart,
    input  logic             Mode,
    input  logic [WIDTH-1:0] Div_sel,
    output logic [WIDTH-1:0] Count,
    output logic             Tick,
    output logic             Y
);

    logic [WIDTH-1:0] cnt,    cnt_nxt;
    logic [WIDTH-1:0] m_act,  m_act_nxt;
    logic             tick_r, tick_nxt;
    logic             y_sq,   y_sq_nxt;
    logic [WIDTH-1:0] m_act_m1;
    logic             parked;
    logic             wrap;

    // Terminal count; only meaningful while the divider is not parked (m_act != 0).
    always_comb begin
        parked   = (m_act == '0);
        m_act_m1 = m_act - WIDTH'(1);
        wrap     = !parked && (cnt == m_act_m1);
    end

    // Next-state: Restart over En; the divisor is only resampled at a wrap,
    // a Restart or while parked, so a running period always finishes with the old M.
    always_comb begin
        cnt_nxt   = cnt;
        m_act_nxt = m_act;
        tick_nxt  = 1'b0;
        y_sq_nxt  = y_sq;
        if (Restart) begin
            cnt_nxt   = '0;
            m_act_nxt = Div_sel;
            y_sq_nxt  = 1'b0;
        end else if (En) begin
            if (parked) begin
                cnt_nxt   = '0;
                m_act_nxt = Div_sel;
            end else if (wrap) begin
                cnt_nxt   = '0;
                m_act_nxt = Div_sel;
                tick_nxt  = 1'b1;
                y_sq_nxt  = ~y_sq;
            end else begin
                cnt_nxt   = cnt + WIDTH'(1);
            end
        end
    end

    // State registers; reset aborts any partial period immediately.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt    <= '0;
            m_act  <= WIDTH'(DEFAULT_DIV);
            tick_r <= 1'b0;
            y_sq   <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            m_act  <= m_act_nxt;
            tick_r <= tick_nxt;
            y_sq   <= y_sq_nxt;
        end
    end

    // Outputs are straight from flops; Y is a plain mux so Mode adds no latency.
    assign Count = cnt;
    assign Tick  = tick_r;
    assign Y     = Mode ? y_sq : tick_r;

endmodule
